// File: rtl/down_timer_if.sv
// Control/status bundle between a local controller and the down_timer.
// The controller (master) drives the command pulses, mode and prescale;
// the timer (slave) returns the registered count and status flags.
interface down_timer_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
);
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  start;
    logic                  stop;
    logic                  count_clr;
    logic                  auto_reload;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  underflow;
    logic                  busy;
    logic                  done;

    modport master (
        output load, load_val, start, stop, count_clr, auto_reload, prescale,
        input  count, underflow, busy, done
    );

    modport slave (
        input  load, load_val, start, stop, count_clr, auto_reload, prescale,
        output count, underflow, busy, done
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with programmable prescaler.
// IDLE holds, RUN decrements once per prescale+1 cycles, and the tick that
// takes the count from 1 to 0 is the terminal tick: it pulses underflow and
// either reloads (auto_reload) or parks the timer in DONE with count 0.
module down_timer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    down_timer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      reload_q, reload_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  uf_q, uf_d;
    logic                  tick;
    logic                  terminal;

    // >= rather than == so lowering prescale below the running prescaler
    // value yields an immediate tick instead of a full wrap of the counter.
    assign tick     = (state_q == RUN) && (presc_q >= bus.prescale);
    assign terminal = tick && (count_q == WIDTH'(1));

    // Next-state logic; priority is count_clr > load > stop > start > tick.
    always_comb begin
        state_d  = (state_q == 2'd3) ? IDLE : state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        uf_d     = 1'b0;

        if (bus.count_clr) begin
            // Reload register is deliberately kept so DONE->start still works.
            count_d = '0;
            presc_d = '0;
            state_d = IDLE;
        end else if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            presc_d  = '0;
            state_d  = IDLE;
        end else if (bus.stop && state_q == RUN) begin
            // Pause only: count and prescaler are held so start resumes in place.
            state_d = IDLE;
        end else if (bus.start && state_q != RUN) begin
            if (state_q == DONE) begin
                count_d = reload_q;
                presc_d = '0;
                state_d = (reload_q != '0) ? RUN : IDLE;
            end else if (count_q != '0) begin
                // Resume from IDLE keeps the partially elapsed prescale period.
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (tick) begin
                presc_d = '0;
                if (terminal) begin
                    uf_d = 1'b1;
                    if (bus.auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PRESCALE_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            uf_q     <= uf_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.underflow = uf_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: a table of per-cycle stimulus rows with
// expected outputs, fed through a scoreboard queue, plus a hand sequence for
// asynchronous reset in the middle of a run.
module tb_down_timer;
    logic clk;
    logic rst_n;

    down_timer_if #(.WIDTH(8), .PRESCALE_W(8)) bus ();

    down_timer #(.WIDTH(8), .PRESCALE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       sp;
        logic       cl;
        logic       ar;
        logic [7:0] ps;
        logic [7:0] c;
        logic       u;
        logic       b;
        logic       d;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       u;
        logic       b;
        logic       d;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic ld, input logic [7:0] lv, input logic st,
                                input logic sp, input logic cl, input logic ar,
                                input logic [7:0] ps, input logic [7:0] c,
                                input logic u, input logic b, input logic d);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.cl = cl; v.ar = ar; v.ps = ps;
        v.c = c; v.u = u; v.b = b; v.d = d;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, nothing expected", name);
        end else begin
            e = sb.pop_front();
            if (bus.count !== e.c || bus.underflow !== e.u || bus.busy !== e.b || bus.done !== e.d) begin
                n_bad++;
                $display("FAIL %s: got count=%0d uf=%0b busy=%0b done=%0b, want count=%0d uf=%0b busy=%0b done=%0b",
                         name, bus.count, bus.underflow, bus.busy, bus.done, e.c, e.u, e.b, e.d);
            end
        end
    endtask

    task automatic expect_out(input logic [7:0] c, input logic u, input logic b, input logic d);
        exp_t e;
        e.c = c; e.u = u; e.b = b; e.d = d;
        sb.push_back(e);
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        bus.load = v.ld; bus.load_val = v.lv; bus.start = v.st; bus.stop = v.sp;
        bus.count_clr = v.cl; bus.auto_reload = v.ar; bus.prescale = v.ps;
        expect_out(v.c, v.u, v.b, v.d);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        vec_t h;
        rst_n = 1'b0;
        bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.count_clr = 1'b0; bus.auto_reload = 1'b0; bus.prescale = '0;

        //   ld lv st sp cl ar ps    c  u  b  d
        // one-shot, prescale 0: 3,2,1,0 then DONE holding 0
        add(1, 3, 0, 0, 0, 0, 0,    3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,    3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    2, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1);
        // start from DONE reloads 3; then clr+load together -> clr wins
        add(0, 0, 1, 0, 0, 0, 0,    3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    2, 0, 1, 0);
        add(1, 7, 0, 0, 1, 0, 0,    0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0);
        // prescale 2: each value held 3 cycles
        add(1, 2, 0, 0, 0, 0, 2,    2, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 2,    2, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2,    2, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2,    2, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2,    0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 2,    0, 0, 0, 1);
        // auto-reload: 2,1,2,1 with underflow on each reload, then drop mode
        add(1, 2, 0, 0, 0, 1, 0,    2, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0,    2, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,    2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,    2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1);
        // stop/resume, and start+stop in RUN pauses
        add(1, 5, 0, 0, 0, 0, 0,    5, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,    5, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    3, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0,    3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,    3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,    3, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0,    3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,    3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    2, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 1);
        // count_clr from DONE, then start with count 0 ignored
        add(0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0);
        // prescale 5, lowered to 1 while prescaler sits at 4 -> immediate tick
        add(1, 4, 0, 0, 0, 0, 5,    4, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 5,    4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 5,    4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 5,    4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 5,    4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 5,    4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1,    3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1,    3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1,    2, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        expect_out(0, 0, 0, 0);
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-run, between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        expect_out(0, 0, 0, 0);
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // After reset the reload register is 0: start from IDLE/0 ignored.
        h = '{ld:0, lv:0, st:1, sp:0, cl:0, ar:0, ps:0, c:0, u:0, b:0, d:0};
        apply(h, "post_reset_start");
        h = '{ld:1, lv:1, st:0, sp:0, cl:0, ar:0, ps:0, c:1, u:0, b:0, d:0};
        apply(h, "load_one");
        h = '{ld:0, lv:0, st:1, sp:0, cl:0, ar:0, ps:0, c:1, u:0, b:1, d:0};
        apply(h, "start_one");
        h = '{ld:0, lv:0, st:0, sp:0, cl:0, ar:0, ps:0, c:0, u:1, b:0, d:1};
        apply(h, "terminal_one");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer with programmable prescaler, one-shot or auto-reload mode, and an underflow event. It is the counting-down complement of the team's up-counter with its all-ones overflow flag. It is used wherever a block must wait a programmed number of ticks and then raise an event, rather than count events up to a limit. It sits beside the up-counter in the control/timing layer and is driven by a local controller or register file.

Parameters:
WIDTH, 8, width of count, load_val and the internal reload register
PRESCALE_W, 8, width of prescale and the internal prescaler counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  pulse; load_val -> count and reload register
load_val  input  WIDTH  value captured on load
start  input  1  pulse; start or resume counting
stop  input  1  pulse; pause counting
count_clr  input  1  pulse; synchronous clear
auto_reload  input  1  1 = periodic, 0 = one-shot
prescale  input  PRESCALE_W  decrement every prescale+1 cycles
count  output  WIDTH  current count value (registered)
underflow  output  1  one-cycle pulse on terminal tick (registered)
busy  output  1  high in RUN
done  output  1  high in DONE (one-shot expired)

Behaviour:
- Reset, asynchronous, on rst_n low, at any time including mid-count:
  - count=0, reload register=0, prescaler counter=0.
  - state=IDLE, underflow=0, busy=0, done=0.
- States are IDLE, RUN and DONE.
  - busy = (state==RUN); done = (state==DONE). Both are decoded from registered state.
- Per-cycle priority, highest first: count_clr > load > stop > start > tick.
- count_clr:
  - count=0, prescaler=0, state -> IDLE, underflow=0.
  - Reload register is unchanged.
- load:
  - count=load_val, reload register=load_val, prescaler=0, state -> IDLE.
  - Applies from any state.
- stop in RUN: state -> IDLE. count and prescaler are held, so start resumes exactly where it stopped. stop outside RUN has no effect.
- start behaviour depends on state:
  - IDLE with count!=0: -> RUN; prescaler is retained.
  - IDLE with count==0: ignored; state stays IDLE.
  - DONE: count=reload register, prescaler=0, -> RUN if the reload register is nonzero, else -> IDLE.
  - RUN: no effect.
- Prescaler, in RUN only:
  - tick = (prescaler >= prescale). Use >= so that a prescale lowered mid-count cannot cause wrap-around.
  - On tick, prescaler=0; otherwise prescaler+1.
  - prescale is sampled every cycle; prescale=0 gives a tick every cycle.
- Tick with count>1: count = count-1.
- Terminal tick (tick with count==1):
  - underflow=1 for exactly the next cycle; de-asserts the following cycle unless another terminal tick occurs.
  - auto_reload is sampled on this cycle.
  - auto_reload=1: count = reload register, state stays RUN.
  - auto_reload=0: count=0, state -> DONE.
- Counting halts in IDLE and DONE: prescaler and count are held and no tick occurs.
- count never wraps below 0. A RUN state with count==0 is unreachable.
- Arithmetic is unsigned, WIDTH bits; no carry or borrow is exported.
- Latency:
  - Control inputs take effect on the next edge.
  - The first decrement after start, from a cleared prescaler, occurs prescale+1 cycles after the start edge.

Test Plan:
1. load_val=3, load, prescale=0, auto_reload=0, start -> count 3,2,1,0 on consecutive cycles after start. underflow high exactly the cycle count becomes 0. done=1, busy=0 thereafter; count held at 0.
2. load_val=2, prescale=2, start -> count stays 2 for 3 cycles, 1 for 3 cycles, then 0; underflow single pulse. Mid-run, lower prescale from 5 to 1 while the prescaler counter is 4 -> tick on the next cycle, no wrap.
3. load_val=2, prescale=0, auto_reload=1, start -> count 2,1,2,1,... with underflow pulsing every 2 cycles, aligned with each reload; busy stays 1. Drop auto_reload -> next terminal tick goes to DONE with count=0.
4. load 5, start, stop after 2 decrements -> count held at 3, busy=0. start -> resumes 3,2,1,0. start and stop in the same cycle while in RUN -> pauses (stop wins).
5. count_clr and load in the same cycle -> count=0, IDLE; start is then ignored. From DONE, start -> reloads the last load_val and runs again.
6. rst_n low mid-RUN, not edge-aligned -> all outputs 0 immediately. After release, start is ignored until a load.
